// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with optional one-entry skid buffer.
// Ports: clk, rst (sync, active-high), flush_i
//   ID side : valid_i/ready_o + inst_i, inst_addr_i, op1_i, op2_i, reg_we_i, reg_waddr_i
//   EX side : valid_o/ready_i + inst_o, inst_addr_o, op1_o, op2_o, reg_we_o, reg_waddr_o
// Config: define ID_EX_SKID_EN for the registered-ready two-entry build.
module id_ex_skid #(
  parameter int DATA_WIDTH  = 32,
  parameter int RDATA_WIDTH = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [DATA_WIDTH-1:0]  inst_addr_i,
  input  logic [RDATA_WIDTH-1:0] op1_i,
  input  logic [RDATA_WIDTH-1:0] op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic [DATA_WIDTH-1:0]  inst_addr_o,
  output logic [RDATA_WIDTH-1:0] op1_o,
  output logic [RDATA_WIDTH-1:0] op2_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o
);

  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  inst;
    logic [DATA_WIDTH-1:0]  addr;
    logic [RDATA_WIDTH-1:0] op1;
    logic [RDATA_WIDTH-1:0] op2;
    logic                   we;
    logic [RADDR_WIDTH-1:0] waddr;
  } pl_t;

  localparam pl_t EMPTY_PL = '{
    inst:  NOP_INST,
    addr:  '0,
    op1:   '0,
    op2:   '0,
    we:    1'b0,
    waddr: '0
  };

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  pl_t    main_q, main_d;
  pl_t    in_pl;
  logic   in_fire, out_fire;

  assign in_pl = '{
    inst:  inst_i,
    addr:  inst_addr_i,
    op1:   op1_i,
    op2:   op2_i,
    we:    reg_we_i,
    waddr: reg_waddr_i
  };

  assign valid_o  = (state_q != EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

`ifdef ID_EX_SKID_EN
  pl_t  skid_q, skid_d;
  logic rdy_q;

  // Own flop so ready_o has no path from ready_i.
  assign ready_o = rdy_q;
`else
  assign ready_o = !valid_o | ready_i;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef ID_EX_SKID_EN
    skid_d  = skid_q;
`endif
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_pl;
`ifdef ID_EX_SKID_EN
        end else if (in_fire) begin
          skid_d  = in_pl;
          state_d = TWO;
`endif
        end else if (out_fire) begin
          main_d  = EMPTY_PL;
          state_d = EMPTY;
        end
      end
`ifdef ID_EX_SKID_EN
      TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = EMPTY_PL;
          state_d = ONE;
        end
      end
`endif
      default: begin
        main_d  = EMPTY_PL;
        state_d = EMPTY;
      end
    endcase
    if (flush_i) begin
      main_d  = EMPTY_PL;
      state_d = EMPTY;
`ifdef ID_EX_SKID_EN
      skid_d  = EMPTY_PL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= EMPTY_PL;
`ifdef ID_EX_SKID_EN
      skid_q  <= EMPTY_PL;
      rdy_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef ID_EX_SKID_EN
      skid_q  <= skid_d;
      rdy_q   <= (state_d != TWO);
`endif
    end
  end

  assign inst_o      = main_q.inst;
  assign inst_addr_o = main_q.addr;
  assign op1_o       = main_q.op1;
  assign op2_o       = main_q.op2;
  assign reg_we_o    = main_q.we;
  assign reg_waddr_o = main_q.waddr;

endmodule

// File: tb/tb_id_ex_skid.sv
// Scoreboard bench for id_ex_skid (either build of ID_EX_SKID_EN).
// Pushes on in_fire, pops and compares on out_fire.
module tb_id_ex_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, ready_o, ready_i, valid_o;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
  logic        reg_we_i, reg_we_o;
  logic [4:0]  reg_waddr_i, reg_waddr_o;

  int checks = 0;
  int errors = 0;

  logic [159:0] sbq[$];
  logic [159:0] in_pk, out_pk, empty_pk;

  always #5 clk = ~clk;

  id_ex_skid dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o)
  );

  assign in_pk  = {26'd0, inst_i, inst_addr_i, op1_i, op2_i,
                   reg_we_i, reg_waddr_i};
  assign out_pk = {26'd0, inst_o, inst_addr_o, op1_o, op2_o,
                   reg_we_o, reg_waddr_o};
  assign empty_pk = {26'd0, NOP, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0};

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst || flush_i) begin
      sbq.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (sbq.size() == 0)
          chk("sb_extra_out", 160'(valid_o), 160'(0));
        else
          chk("payload", out_pk, sbq.pop_front());
      end
      if (!valid_o)
        chk("empty_payload", out_pk, empty_pk);
      if (valid_i && ready_o)
        sbq.push_back(in_pk);
    end
  end

  task automatic send(input logic [31:0] inst, input logic [31:0] addr,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] wa);
    valid_i = 1'b1;
    inst_i = inst;
    inst_addr_i = addr;
    op1_i = a;
    op2_i = b;
    reg_we_i = 1'b1;
    reg_waddr_i = wa;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    reg_we_i = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 160'(valid_o), 160'(0));
    chk({tag, "_ready"}, 160'(ready_o), 160'(1));
    chk({tag, "_payload"}, out_pk, empty_pk);
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b1;
    send(32'hdead_beef, 32'h40, 32'h1, 32'h2, 5'd3);
    repeat (2) begin
      @(negedge clk);
      chk_reset("rst");
      chk("rst_we", 160'(reg_we_o), 160'(0));
    end
    nxt();
    rst = 1'b0;
    send(32'h0070_8293, 32'h100, 32'h10, 32'h7, 5'd5);
    @(negedge clk);
    chk("first_ready", 160'(ready_o), 160'(1));
    nxt();
    idle();
    @(negedge clk);
    chk("lat_valid", 160'(valid_o), 160'(1));
    chk("lat_inst", 160'(inst_o), 160'(32'h0070_8293));
    nxt();

    for (int i = 0; i < 4; i++) begin
      send(32'h0010_0093 + (i << 7), 32'h200 + 4 * i,
           32'h100 + i, 32'h20 + i, 5'(i + 1));
      @(negedge clk);
      chk("stream_ready", 160'(ready_o), 160'(1));
      if (i > 0) chk("stream_valid", 160'(valid_o), 160'(1));
      nxt();
    end
    idle();
    @(negedge clk);
    chk("stream_last", 160'(valid_o), 160'(1));
    nxt();

`ifdef ID_EX_SKID_EN
    ready_i = 1'b0;
    send(32'h00a0_0113, 32'h300, 32'haa, 32'h1, 5'd2);
    @(negedge clk);
    chk("bp_ready_a", 160'(ready_o), 160'(1));
    nxt();
    send(32'h00b0_0193, 32'h304, 32'hbb, 32'h2, 5'd3);
    @(negedge clk);
    chk("bp_ready_b", 160'(ready_o), 160'(1));
    nxt();
    idle();
    repeat (2) begin
      @(negedge clk);
      chk("bp_ready_low", 160'(ready_o), 160'(0));
      chk("bp_hold", 160'(inst_o), 160'(32'h00a0_0113));
      nxt();
    end
    send(32'h00c0_0213, 32'h308, 32'hcc, 32'h3, 5'd4);
    flush_i = 1'b1;
    @(negedge clk);
    nxt();
    flush_i = 1'b0;
    idle();
    @(negedge clk);
    chk_reset("flush");
    chk("flush_we", 160'(reg_we_o), 160'(0));
    nxt();
    ready_i = 1'b1;
    repeat (3) nxt();

    ready_i = 1'b0;
    send(32'h0110_0293, 32'h400, 32'h11, 32'h4, 5'd5);
    nxt();
    send(32'h0120_0313, 32'h404, 32'h12, 32'h5, 5'd6);
    nxt();
    idle();
    @(negedge clk);
    chk("two_ready", 160'(ready_o), 160'(0));
    nxt();
    ready_i = 1'b1;
    @(negedge clk);
    chk("drain_a", 160'(inst_o), 160'(32'h0110_0293));
    chk("drain_a_ready", 160'(ready_o), 160'(0));
    nxt();
    @(negedge clk);
    chk("drain_b", 160'(inst_o), 160'(32'h0120_0313));
    chk("drain_b_ready", 160'(ready_o), 160'(1));
    nxt();

    ready_i = 1'b0;
    send(32'h0130_0393, 32'h500, 32'h13, 32'h6, 5'd7);
    nxt();
    send(32'h0140_0413, 32'h504, 32'h14, 32'h7, 5'd8);
    nxt();
    idle();
    @(negedge clk);
    chk("stall_ready", 160'(ready_o), 160'(0));
    nxt();
`else
    ready_i = 1'b0;
    send(32'h00a0_0113, 32'h300, 32'haa, 32'h1, 5'd2);
    @(negedge clk);
    chk("ns_ready_empty", 160'(ready_o), 160'(1));
    nxt();
    send(32'h00b0_0193, 32'h304, 32'hbb, 32'h2, 5'd3);
    @(negedge clk);
    chk("ns_ready_low", 160'(ready_o), 160'(0));
    chk("ns_hold", 160'(inst_o), 160'(32'h00a0_0113));
    nxt();
    ready_i = 1'b1;
    #1;
    chk("ns_ready_comb", 160'(ready_o), 160'(1));
    nxt();
    idle();
    ready_i = 1'b0;
    @(negedge clk);
    chk("ns_replace", 160'(inst_o), 160'(32'h00b0_0193));
    chk("ns_replace_valid", 160'(valid_o), 160'(1));
    nxt();
    send(32'h00c0_0213, 32'h308, 32'hcc, 32'h3, 5'd4);
    flush_i = 1'b1;
    @(negedge clk);
    nxt();
    flush_i = 1'b0;
    idle();
    @(negedge clk);
    chk_reset("flush");
    chk("flush_we", 160'(reg_we_o), 160'(0));
    nxt();
    ready_i = 1'b1;
    repeat (3) nxt();
    ready_i = 1'b0;
    send(32'h0130_0393, 32'h500, 32'h13, 32'h6, 5'd7);
    nxt();
    idle();
    @(negedge clk);
    chk("stall_valid", 160'(valid_o), 160'(1));
    nxt();
`endif

    rst = 1'b1;
    flush_i = 1'b1;
    send(32'h0150_0493, 32'h600, 32'h15, 32'h8, 5'd9);
    @(negedge clk);
    nxt();
    rst = 1'b0;
    flush_i = 1'b0;
    idle();
    @(negedge clk);
    chk_reset("rst_stall");
    nxt();
    ready_i = 1'b1;
    repeat (5) nxt();
    chk("sb_drain", 160'(sbq.size()), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
